// File: rtl/uart_msg_decoder.sv
// rtl/uart_msg_decoder.sv - framed SOF/CMD/ARG/EOF command decoder; UART_MSG_DECODER_CHECKSUM_EN adds a CHK byte
module uart_msg_decoder #(
    parameter int                          DATA_W    = 8,
    parameter int                          NUM_CMD   = 4,
    parameter logic [NUM_CMD*DATA_W-1:0]   CMD_CODES = {8'h53, 8'h50, 8'h4C, 8'h52},
    parameter logic [DATA_W-1:0]           SOF       = 8'h23,
    parameter logic [DATA_W-1:0]           EOF       = 8'h0A,
    parameter int                          TIMEOUT   = 1000000,
    parameter int                          TO_W      = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               enable,
    input  logic [NUM_CMD-1:0] flag_clr,
    output logic [NUM_CMD-1:0] cmd_pulse,
    output logic [NUM_CMD-1:0] cmd_flag,
    output logic [DATA_W-1:0]  cmd_arg,
    output logic               frame_err,
    output logic               busy
);

    localparam int IDX_W = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GET_CMD = 3'd1;
    localparam logic [2:0] GET_ARG = 3'd2;
    localparam logic [2:0] GET_EOF = 3'd3;
`ifdef UART_MSG_DECODER_CHECKSUM_EN
    localparam logic [2:0] GET_CHK = 3'd4;
`endif

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] arg_pend;
    logic [TO_W-1:0]   to_cnt;
`ifdef UART_MSG_DECODER_CHECKSUM_EN
    logic [DATA_W-1:0] cmd_byte;
`endif

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              to_fire;

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CMD - 1; i >= 0; i--) begin
            if (rx_data == CMD_CODES[i*DATA_W +: DATA_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign to_fire = (TIMEOUT > 0) && enable && (state != IDLE) && !rx_valid && (to_cnt == TO_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            arg_pend  <= '0;
            to_cnt    <= '0;
            cmd_pulse <= '0;
            cmd_flag  <= '0;
            cmd_arg   <= '0;
            frame_err <= 1'b0;
`ifdef UART_MSG_DECODER_CHECKSUM_EN
            cmd_byte  <= '0;
`endif
        end else begin
            cmd_pulse <= '0;
            frame_err <= 1'b0;
            cmd_flag  <= cmd_flag & ~flag_clr;
            if (!enable) begin
                state    <= IDLE;
                cmd_flag <= '0;
                to_cnt   <= '0;
            end else begin
                if (state == IDLE || rx_valid || to_fire) begin
                    to_cnt <= '0;
                end else if (to_cnt != '1) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end

                if (to_fire) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                end else if (rx_valid) begin
                    case (state)
                        IDLE: begin
                            if (rx_data == SOF) state <= GET_CMD;
                        end
                        GET_CMD: begin
                            if (rx_data == SOF) begin
                                state <= GET_CMD;
                            end else if (hit) begin
                                idx   <= hit_idx;
`ifdef UART_MSG_DECODER_CHECKSUM_EN
                                cmd_byte <= rx_data;
`endif
                                state <= GET_ARG;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                        GET_ARG: begin
                            arg_pend <= rx_data;
`ifdef UART_MSG_DECODER_CHECKSUM_EN
                            state    <= GET_CHK;
`else
                            state    <= GET_EOF;
`endif
                        end
`ifdef UART_MSG_DECODER_CHECKSUM_EN
                        GET_CHK: begin
                            if (rx_data == (cmd_byte ^ arg_pend)) begin
                                state <= GET_EOF;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end
`endif
                        GET_EOF: begin
                            // The set is written after the clear above, so it wins on the same bit.
                            if (rx_data == EOF) begin
                                cmd_pulse[idx] <= 1'b1;
                                cmd_flag[idx]  <= 1'b1;
                                cmd_arg        <= arg_pend;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
